// File: rtl/logicnet_input_quantizer.sv
// rtl/logicnet_input_quantizer.sv - quantizes raw feature beats to 2-bit codes and assembles the layer-0 input vector
module logicnet_input_quantizer #(
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_W = 8,
  parameter logic [FEAT_W-1:0] THR0 = FEAT_W'(64),
  parameter logic [FEAT_W-1:0] THR1 = FEAT_W'(128),
  parameter logic [FEAT_W-1:0] THR2 = FEAT_W'(192)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [FEAT_W-1:0]         s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [2*NUM_FEATURES-1:0] m_data,
  output logic                      err_short,
  output logic                      err_long,
  output logic [15:0]               sample_count
);

  localparam int IDX_W = $clog2(NUM_FEATURES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  typedef enum logic [1:0] {COLLECT, HOLD, SKIP} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [2*NUM_FEATURES-1:0] asm_q;
  logic [2*NUM_FEATURES-1:0] asm_next;
  logic [1:0]                code;
  logic                      accept;
  logic                      out_free;

  always_comb begin
    code = 2'd0;
    if (s_data >= THR2)
      code = 2'd3;
    else if (s_data >= THR1)
      code = 2'd2;
    else if (s_data >= THR0)
      code = 2'd1;
    asm_next = asm_q;
    asm_next[2*idx +: 2] = code;
  end

  assign accept   = s_valid && s_ready;
  assign out_free = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      idx          <= '0;
      asm_q        <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      sample_count <= '0;
      s_ready      <= 1'b0;
    end else begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      s_ready   <= 1'b1;
      if (m_valid && m_ready) begin
        m_valid      <= 1'b0;
        sample_count <= sample_count + 16'd1;
      end
      case (state)
        COLLECT: begin
          if (accept) begin
            asm_q <= asm_next;
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (!s_last) begin
                err_long <= 1'b1;
                state    <= SKIP;
              end else if (out_free) begin
                m_data  <= asm_next;
                m_valid <= 1'b1;
              end else begin
                state   <= HOLD;
                s_ready <= 1'b0;
              end
            end else if (s_last) begin
              idx       <= '0;
              err_short <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        HOLD: begin
          // The completed vector waits in asm_q until the output register drains.
          if (out_free) begin
            m_data  <= asm_q;
            m_valid <= 1'b1;
            state   <= COLLECT;
          end else begin
            s_ready <= 1'b0;
          end
        end
        SKIP: begin
          if (accept && s_last)
            state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// tb/tb_logicnet_input_quantizer.sv - self-checking bench for logicnet_input_quantizer
module tb_logicnet_input_quantizer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [7:0]   s_data = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [2*N-1:0] m_data;
  logic         err_short;
  logic         err_long;
  logic [15:0]  sample_count;

  logicnet_input_quantizer #(
    .NUM_FEATURES(N), .FEAT_W(8), .THR0(8'd64), .THR1(8'd128), .THR2(8'd192)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err_short(err_short), .err_long(err_long), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          cur[$];
  bit          skipping = 0;
  logic [2*N-1:0] exp_q[$];
  int          exp_cnt = 0;
  bit          exp_short, exp_long;
  bit          acc;
  bit          rand_rdy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int quant(input int x);
    return int'(x >= 64) + int'(x >= 128) + int'(x >= 192);
  endfunction

  task automatic model_beat(input int d, input bit last);
    logic [2*N-1:0] v;
    if (skipping) begin
      if (last) skipping = 0;
    end else begin
      cur.push_back(quant(d));
      if (cur.size() == N) begin
        if (last) begin
          v = '0;
          for (int i = 0; i < N; i++) v = v | ((2*N)'(cur[i]) << (2*i));
          exp_q.push_back(v);
        end else begin
          exp_long = 1;
          skipping = 1;
        end
        cur.delete();
      end else if (last) begin
        exp_short = 1;
        cur.delete();
      end
    end
  endtask

  task automatic tick();
    if (rand_rdy) m_ready = ($urandom % 3) != 0;
    @(negedge clk);
    acc = s_valid && s_ready;
    if (m_valid) begin
      if (exp_q.size() == 0)
        chk("spurious_m_valid", 32'd1, 32'd0);
      else
        chk("m_data", m_data, exp_q[0]);
      if (m_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        exp_cnt++;
      end
    end
    exp_short = 0;
    exp_long = 0;
    if (acc) model_beat(int'(s_data), s_last);
    @(posedge clk);
    #1;
    chk("err_short", err_short, exp_short);
    chk("err_long", err_long, exp_long);
  endtask

  task automatic send_beat(input int d, input bit last);
    s_valid = 1'b1;
    s_data = 8'(d);
    s_last = last;
    acc = 0;
    for (int t = 0; t < 100 && !acc; t++) tick();
    if (!acc) chk("beat_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_last = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", {err_short, err_long}, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_s_ready", s_ready, 0);
    cur.delete();
    exp_q.delete();
    skipping = 0;
    exp_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int t = 0; t < 50 && (exp_q.size() != 0 || m_valid); t++) tick();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_m_valid", m_valid, 0);
    chk("sample_count", sample_count, 32'(exp_cnt[15:0]));
  endtask

  initial begin
    do_reset();
    tick();
    chk("s_ready_after_reset", s_ready, 1);

    // Basic sample with one-cycle latency
    m_ready = 1'b1;
    send_beat(10, 0); send_beat(64, 0); send_beat(150, 0); send_beat(255, 1);
    chk("lat_m_valid", m_valid, 1);
    chk("vec_basic", m_data, 8'b11_10_01_00);
    tick();
    chk("count_one", sample_count, 1);

    // Threshold boundaries, back-to-back
    send_beat(63, 0); send_beat(127, 0); send_beat(191, 0); send_beat(192, 1);
    chk("vec_bound_a", m_data, 8'b11_10_01_00);
    send_beat(0, 0); send_beat(128, 0); send_beat(64, 0); send_beat(255, 1);
    chk("vec_bound_b", m_data, 8'b11_01_10_00);
    drain();

    // Backpressure: second vector parks in HOLD
    m_ready = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < N; b++) send_beat($urandom_range(0, 255), b == N-1);
    chk("hold_s_ready", s_ready, 0);
    chk("hold_m_valid", m_valid, 1);
    drain();
    chk("count_after_hold", sample_count, 5);

    // Short sample
    send_beat(200, 0); send_beat(30, 1);
    chk("short_pulse", err_short, 1);
    tick();
    chk("short_no_valid", m_valid, 0);
    for (int b = 0; b < N; b++) send_beat($urandom_range(0, 255), b == N-1);
    drain();

    // Long sample
    for (int b = 0; b < 6; b++) begin
      send_beat($urandom_range(0, 255), b == 5);
      if (b == 3) chk("long_pulse", err_long, 1);
    end
    tick();
    chk("long_no_valid", m_valid, 0);
    for (int b = 0; b < N; b++) send_beat($urandom_range(0, 255), b == N-1);
    drain();

    // Reset mid-sample
    send_beat(100, 0); send_beat(250, 0);
    do_reset();
    send_beat(255, 0); send_beat(0, 0); send_beat(130, 0); send_beat(70, 1);
    chk("vec_after_reset", m_data, 8'b01_10_00_11);
    drain();
    chk("count_after_reset", sample_count, 1);

    // Randomized traffic with random gaps and backpressure
    rand_rdy = 1;
    for (int s = 0; s < 150; s++) begin
      int len;
      len = ($urandom % 10 < 7) ? N : int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) begin
        if ($urandom % 4 == 0) tick();
        send_beat($urandom_range(0, 255), b == len-1);
      end
    end
    rand_rdy = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
